// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU MEM-stage, debug/loader and data-memory signals seen by dmem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline/memory/debugger.
interface dmem_arbiter_if #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
);
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [DM_ADDRESS-1:0] cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [2:0]            cpu_func3;
  logic                  cpu_stall;

  logic                  dbg_req;
  logic                  dbg_we;
  logic [DM_ADDRESS-1:0] dbg_addr;
  logic [DATA_W-1:0]     dbg_wdata;
  logic                  dbg_ack;
  logic [DATA_W-1:0]     dbg_rdata;

  logic                  mem_rd;
  logic                  mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_func3;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_func3,
    output cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, cpu_func3,
    input  cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU MEM stage has priority, a debug/loader word access is granted
// when the CPU is quiet or after the debug request has been denied STARVE_MAX times.
module dmem_arbiter #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned    CntW      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(STARVE_MAX);
  localparam logic [2:0]     Func3Word = 3'b010;

  typedef enum logic [1:0] {StIdle, StDbgAcc, StDbgRsp} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       starve_cnt_q, starve_cnt_d;
  logic                  dbg_we_q, dbg_we_d;
  logic [DM_ADDRESS-1:0] dbg_addr_q, dbg_addr_d;
  logic [DATA_W-1:0]     dbg_wdata_q, dbg_wdata_d;
  logic [DATA_W-1:0]     dbg_rdata_q, dbg_rdata_d;

  logic              cpu_pend;
  logic              dbg_grant;
  logic [DATA_W-1:0] rsp_data;

  assign cpu_pend  = bus.cpu_rd | bus.cpu_wr;
  // Starved debug is granted on the same edge the CPU access completes, so the CPU never waits
  // in the granting cycle itself.
  assign dbg_grant = (state_q == StIdle) && bus.dbg_req &&
                     (!cpu_pend || (starve_cnt_q == CntMax));
  assign rsp_data  = dbg_we_q ? '0 : bus.mem_rdata;

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    dbg_we_d     = dbg_we_q;
    dbg_addr_d   = dbg_addr_q;
    dbg_wdata_d  = dbg_wdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (dbg_grant) begin
          state_d     = StDbgAcc;
          dbg_we_d    = bus.dbg_we;
          dbg_addr_d  = bus.dbg_addr;
          dbg_wdata_d = bus.dbg_wdata;
        end else if (bus.dbg_req && cpu_pend && (starve_cnt_q != CntMax)) begin
          starve_cnt_d = starve_cnt_q + CntW'(1);
        end
      end
      StDbgAcc: state_d = StDbgRsp;
      StDbgRsp: begin
        state_d     = StIdle;
        dbg_rdata_d = rsp_data;
      end
      default: state_d = StIdle;
    endcase
    if (!bus.dbg_req || dbg_grant) begin
      starve_cnt_d = '0;
    end
  end

  always_comb begin
    bus.mem_rd    = bus.cpu_rd & ~bus.cpu_wr;
    bus.mem_wr    = bus.cpu_wr;
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_func3 = bus.cpu_func3;
    bus.cpu_stall = 1'b0;
    bus.dbg_ack   = 1'b0;
    bus.dbg_rdata = dbg_rdata_q;
    unique case (state_q)
      StDbgAcc: begin
        bus.mem_rd    = ~dbg_we_q;
        bus.mem_wr    = dbg_we_q;
        bus.mem_addr  = dbg_addr_q;
        bus.mem_wdata = dbg_wdata_q;
        bus.mem_func3 = Func3Word;
        bus.cpu_stall = 1'b1;
      end
      // Read data shows up in the ack cycle and is held by dbg_rdata_q afterwards.
      StDbgRsp: begin
        bus.dbg_ack   = 1'b1;
        bus.dbg_rdata = rsp_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      dbg_we_q     <= 1'b0;
      dbg_addr_q   <= '0;
      dbg_wdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      dbg_we_q     <= dbg_we_d;
      dbg_addr_q   <= dbg_addr_d;
      dbg_wdata_q  <= dbg_wdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, all checked per cycle
// against a transaction-level reference model with its own shadow of memory contents.
module tb_dmem_arbiter;
  localparam int unsigned AW   = 9;
  localparam int unsigned DW   = 32;
  localparam int          SMAX = 4;

  logic clk;
  logic reset;

  dmem_arbiter_if #(.DM_ADDRESS(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read data memory behind the arbiter.
  logic [DW-1:0] mem [512] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what memory should contain and where the debug transaction stands.
  logic [DW-1:0] ref_mem [512] = '{default: '0};
  int            phase     = 0;  // 0 arbitrating, 1 debug owns memory, 2 debug acknowledged
  int            starve    = 0;
  int            req_start = -1;
  int            cyc       = 0;
  logic          l_we      = 1'b0;
  logic [AW-1:0] l_addr    = '0;
  logic [DW-1:0] l_wdata   = '0;
  logic [DW-1:0] acc_rd    = '0;
  logic [DW-1:0] held      = '0;

  logic          saw_ack, saw_stall;
  logic [DW-1:0] saw_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase     = 0;
    starve    = 0;
    req_start = -1;
    held      = '0;
  endtask

  // Check outputs mid-cycle, then advance the model across the rising edge.
  task automatic cycle();
    logic          pend;
    logic [DW-1:0] rsp;
    @(negedge clk);
    pend      = bus.cpu_rd | bus.cpu_wr;
    rsp       = l_we ? '0 : acc_rd;
    saw_ack   = bus.dbg_ack;
    saw_stall = bus.cpu_stall;
    saw_rdata = bus.dbg_rdata;
    if (phase == 1) begin
      chk("acc_stall", 32'(bus.cpu_stall), 32'd1);
      chk("acc_mem_wr", 32'(bus.mem_wr), 32'(l_we));
      chk("acc_mem_rd", 32'(bus.mem_rd), 32'(!l_we));
      chk("acc_mem_addr", 32'(bus.mem_addr), 32'(l_addr));
      chk("acc_func3", 32'(bus.mem_func3), 32'd2);
      if (l_we) chk("acc_wdata", bus.mem_wdata, l_wdata);
      chk("acc_ack", 32'(bus.dbg_ack), 32'd0);
      chk("acc_rdata_hold", bus.dbg_rdata, held);
    end else begin
      chk("stall", 32'(bus.cpu_stall), 32'd0);
      chk("mem_wr", 32'(bus.mem_wr), 32'(bus.cpu_wr));
      chk("mem_rd", 32'(bus.mem_rd), 32'(bus.cpu_rd && !bus.cpu_wr));
      if (pend) begin
        chk("mem_addr", 32'(bus.mem_addr), 32'(bus.cpu_addr));
        chk("mem_func3", 32'(bus.mem_func3), 32'(bus.cpu_func3));
      end
      if (bus.cpu_wr) chk("mem_wdata", bus.mem_wdata, bus.cpu_wdata);
      chk("ack", 32'(bus.dbg_ack), 32'(phase == 2));
      chk("dbg_rdata", bus.dbg_rdata, (phase == 2) ? rsp : held);
      if (phase == 2) begin
        chk("latency_bound", 32'((cyc - req_start) <= SMAX + 2), 32'd1);
        req_start = -1;
      end
    end
    @(posedge clk);
    case (phase)
      0: begin
        if (bus.cpu_wr) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
        if (bus.dbg_req && req_start < 0) req_start = cyc;
        if (!bus.dbg_req) req_start = -1;
        if (bus.dbg_req && (!pend || starve == SMAX)) begin
          phase   = 1;
          starve  = 0;
          l_we    = bus.dbg_we;
          l_addr  = bus.dbg_addr;
          l_wdata = bus.dbg_wdata;
        end else if (!bus.dbg_req) begin
          starve = 0;
        end else if (pend && starve < SMAX) begin
          starve++;
        end
      end
      1: begin
        if (l_we) ref_mem[l_addr] = l_wdata;
        else      acc_rd = ref_mem[l_addr];
        phase = 2;
      end
      default: begin
        if (bus.cpu_wr) ref_mem[bus.cpu_addr] = bus.cpu_wdata;
        held  = rsp;
        phase = 0;
      end
    endcase
    cyc++;
    #1;
  endtask

  task automatic cpu_set(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.cpu_rd    = rd;
    bus.cpu_wr    = wr;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_func3 = 3'b010;
  endtask

  task automatic dbg_set(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.dbg_req   = req;
    bus.dbg_we    = we;
    bus.dbg_addr  = a;
    bus.dbg_wdata = d;
  endtask

  initial begin
    int ack_k;
    int n_stall;
    int busy;

    reset = 1'b0;
    cpu_set(1'b0, 1'b0, '0, '0);
    dbg_set(1'b0, 1'b0, '0, '0);
    #3;
    chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
    chk("rst_ack", 32'(bus.dbg_ack), 32'd0);
    chk("rst_rdata", bus.dbg_rdata, 32'd0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // CPU-only write stream: memory port mirrors the CPU, never stalled.
    cpu_set(1'b0, 1'b1, 9'h010, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("cpu_only_stall", 32'(saw_stall), 32'd0);
    end
    cpu_set(1'b1, 1'b1, 9'h011, 32'h0BADF00D);  // read+write acts as a write
    cycle();
    cpu_set(1'b0, 1'b0, '0, '0);
    cycle();

    // Debug write with idle CPU; later dbg_* changes must be ignored.
    dbg_set(1'b1, 1'b1, 9'h020, 32'h12345678);
    cycle();
    dbg_set(1'b0, 1'b1, 9'h033, 32'hFFFFFFFF);
    cycle();
    chk("dwr_stall", 32'(saw_stall), 32'd1);
    cycle();
    chk("dwr_ack", 32'(saw_ack), 32'd1);
    chk("dwr_rdata", saw_rdata, 32'd0);

    // Debug read-back of the same word.
    dbg_set(1'b1, 1'b0, 9'h020, 32'h0);
    cycle();
    dbg_set(1'b0, 1'b0, 9'h000, 32'h0);
    cycle();
    cycle();
    chk("drd_ack", 32'(saw_ack), 32'd1);
    chk("drd_rdata", saw_rdata, 32'h12345678);
    cycle();
    chk("drd_hold", saw_rdata, 32'h12345678);

    // Busy CPU, held debug read: ack at cycle STARVE_MAX+2 with a single stall cycle.
    cpu_set(1'b1, 1'b0, 9'h011, 32'h0);
    dbg_set(1'b1, 1'b0, 9'h010, 32'h0);
    ack_k = -1;
    n_stall = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (saw_stall) n_stall++;
      if (saw_ack && ack_k < 0) begin
        ack_k = k;
        chk("starve_rdata", saw_rdata, 32'hDEADBEEF);
        bus.dbg_req = 1'b0;
      end
    end
    chk("starve_ack_cycle", 32'(ack_k), 32'd6);
    chk("starve_stall_cnt", 32'(n_stall), 32'd1);

    // Request dropped after 2 denials, then reasserted: full starvation window again.
    dbg_set(1'b1, 1'b0, 9'h011, 32'h0);
    cycle();
    cycle();
    bus.dbg_req = 1'b0;
    cycle();
    bus.dbg_req = 1'b1;
    ack_k = -1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (saw_ack && ack_k < 0) begin
        ack_k = k;
        chk("restart_rdata", saw_rdata, 32'h0BADF00D);
        bus.dbg_req = 1'b0;
      end
    end
    chk("restart_ack_cycle", 32'(ack_k), 32'd6);

    // Reset in the middle of a debug access: no ack, back to idle.
    cpu_set(1'b0, 1'b0, '0, '0);
    dbg_set(1'b1, 1'b1, 9'h030, 32'hA5A5A5A5);
    cycle();
    bus.dbg_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("abort_stall", 32'(bus.cpu_stall), 32'd0);
    chk("abort_ack", 32'(bus.dbg_ack), 32'd0);
    chk("abort_rdata", bus.dbg_rdata, 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("abort_no_ack", 32'(saw_ack), 32'd0);
    end

    // Random traffic at falling CPU load levels.
    for (int i = 0; i < 1500; i++) begin
      busy = (i < 500) ? 90 : (i < 1000) ? 40 : 5;
      bus.cpu_rd    = ($urandom_range(99) < busy);
      bus.cpu_wr    = ($urandom_range(99) < busy / 2);
      bus.cpu_addr  = AW'($urandom_range(15));
      bus.cpu_wdata = $urandom;
      bus.cpu_func3 = 3'($urandom_range(7));
      if (bus.dbg_req) begin
        if ($urandom_range(99) < (saw_ack ? 50 : 5)) bus.dbg_req = 1'b0;
      end else begin
        bus.dbg_req = ($urandom_range(99) < 25);
      end
      bus.dbg_we    = 1'($urandom_range(1));
      bus.dbg_addr  = AW'($urandom_range(15));
      bus.dbg_wdata = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DM_ADDRESS, default 9, data-memory byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, max consecutive cycles a pending debug request is denied.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports cpu_rd, cpu_wr  input  1 each  MEM-stage read and write strobes.
REQ-007 SHALL have ports cpu_addr  input  DM_ADDRESS; cpu_wdata  input  DATA_W; cpu_func3  input  3  MEM-stage access fields.
REQ-008 SHALL have port cpu_stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB this cycle.
REQ-009 SHALL have ports dbg_req  input  1; dbg_we  input  1; dbg_addr  input  DM_ADDRESS; dbg_wdata  input  DATA_W  debug/loader request, word access.
REQ-010 SHALL have ports dbg_ack  output  1; dbg_rdata  output  DATA_W  debug completion pulse and read data.
REQ-011 SHALL have ports mem_rd, mem_wr  output  1; mem_addr  output  DM_ADDRESS; mem_wdata  output  DATA_W; mem_func3  output  3  to datamemory.
REQ-012 SHALL have port mem_rdata  input  DATA_W  datamemory read data, valid the cycle after mem_rd.

Function
REQ-013 SHALL implement states IDLE, DBG_ACC, DBG_RSP.
REQ-014 SHALL drive mem_* combinationally from cpu_* in IDLE and DBG_RSP: CPU access has zero added latency, cpu_stall=0.
REQ-015 SHALL treat a CPU access as pending when cpu_rd|cpu_wr; cpu_rd&cpu_wr together is a write (mem_wr=1, mem_rd=0).
REQ-016 SHALL move IDLE->DBG_ACC at the clock edge where dbg_req=1 and (no CPU access pending or starve_cnt==STARVE_MAX).
REQ-017 SHALL latch dbg_we, dbg_addr, dbg_wdata on the IDLE->DBG_ACC edge; later changes to dbg_* are ignored until dbg_ack.
REQ-018 SHALL in DBG_ACC drive mem_* from latched debug fields, mem_func3=3'b010 (word), and assert cpu_stall=1 regardless of CPU request.
REQ-019 SHALL move DBG_ACC->DBG_RSP unconditionally after one cycle.
REQ-020 SHALL in DBG_RSP assert dbg_ack=1 for exactly one cycle; dbg_rdata=mem_rdata for reads, 0 for writes; registered so dbg_rdata holds until next dbg_ack.
REQ-021 SHALL move DBG_RSP->IDLE unconditionally; a dbg_req still high in DBG_RSP is a new request, evaluated from IDLE next cycle.
REQ-022 SHALL keep starve_cnt (width clog2(STARVE_MAX+1)): +1 each IDLE cycle with dbg_req=1 and a CPU access pending; saturates at STARVE_MAX; cleared on entry to DBG_ACC and whenever dbg_req=0.
REQ-023 SHALL, when starve_cnt==STARVE_MAX and a CPU access is pending in IDLE, still service the CPU access that cycle (no stall) and grant debug on that edge; the CPU is stalled only in the following DBG_ACC cycle.
REQ-024 SHALL deassert mem_rd and mem_wr in IDLE/DBG_RSP when no CPU access is pending (no spurious memory access).
REQ-025 SHALL guarantee worst-case debug latency dbg_req->dbg_ack of STARVE_MAX+2 cycles.

Reset
REQ-026 SHALL on reset=0, asynchronously: state=IDLE, starve_cnt=0, latched debug fields=0, dbg_ack=0, dbg_rdata=0, cpu_stall=0.
REQ-027 SHALL abort any in-flight debug transaction on reset mid-DBG_ACC/DBG_RSP with no dbg_ack; memory write in DBG_ACC is not guaranteed.
REQ-028 SHALL resume arbitration on the first rising edge after reset returns to 1.

Verification
REQ-029 SHALL pass: CPU-only stream (cpu_wr, addr 0x010, data 0xDEADBEEF), dbg_req=0 -> mem_* mirror cpu_* same cycle, cpu_stall=0 always.
REQ-030 SHALL pass: idle CPU, dbg write addr 0x020 data 0x12345678 -> DBG_ACC next cycle with mem_wr=1, mem_func3=010; dbg_ack one cycle later, dbg_rdata=0.
REQ-031 SHALL pass: dbg read addr 0x020 after REQ-030 -> dbg_ack 2 cycles after grant edge with dbg_rdata=0x12345678.
REQ-032 SHALL pass: CPU access every cycle, dbg_req held -> grant after 4 denied cycles, cpu_stall=1 exactly one cycle, dbg_ack at cycle 6 after dbg_req.
REQ-033 SHALL pass: dbg_req dropped after 2 denied cycles then reasserted -> starve_cnt restarts from 0.
REQ-034 SHALL pass: reset=0 asserted during DBG_ACC -> cpu_stall=0, dbg_ack=0 immediately, state IDLE, no ack after release.
